// File: rtl/dmem_store_buffer_if.sv
// Purpose : memory-side write port of the data store buffer (head entry out, read data in).
// Latency : pure wiring; timing is set by the buffer and the memory on either side.
// Backpressure: the memory holds mem_ready low to stall the drain; head fields stay stable meanwhile.
// Signals : mem_valid/mem_ready handshake, mem_addr (word aligned), mem_wdata/mem_be lane data,
//           mem_rdata combinational read of the word addressed by the core this cycle.
interface dmem_store_buffer_if #(
    parameter int AW = 32
);
    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic [31:0]   mem_rdata;

    // master: the store buffer; slave: the data memory
    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_be,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_be,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/dmem_store_buffer.sv
// Purpose : posted-write store buffer between a single-cycle core data port and a slower memory.
// Latency : store accepted in cycle N is presented to memory no earlier than N+1; loads forward combinationally.
// Backpressure: stall when full with no same-cycle pop; memory mem_ready=0 holds the head entry.
// Ports   : clk, reset (async active-low); core side memwrite/aluout/writedata/readdata/stall/misalign;
//           status count/empty; mem = memory write port (see dmem_store_buffer_if).
module dmem_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               memwrite,
    input  logic [AW-1:0]            aluout,
    input  logic [31:0]              writedata,
    output logic [31:0]              readdata,
    output logic                     stall,
    output logic                     misalign,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    dmem_store_buffer_if.master      mem
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [AW-3:0] waddr;
        logic [3:0]    be;
        logic [31:0]   data;
    } entry_t;

    entry_t           ent_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;

    entry_t new_ent;
    logic   legal;
    logic   misal;
    logic   full;
    logic   deq;
    logic   enq;

    // Store decode and lane formatting. Data is replicated across lanes so
    // the memory only has to honour the byte enables.
    always_comb begin
        new_ent       = '0;
        new_ent.waddr = aluout[AW-1:2];
        legal         = 1'b0;
        misal         = 1'b0;
        case (memwrite)
            2'b01: begin
                legal        = 1'b1;
                new_ent.be   = 4'b0001 << aluout[1:0];
                new_ent.data = {4{writedata[7:0]}};
            end
            2'b10: begin
                legal        = ~aluout[0];
                misal        = aluout[0];
                new_ent.be   = aluout[1] ? 4'b1100 : 4'b0011;
                new_ent.data = {2{writedata[15:0]}};
            end
            2'b11: begin
                legal        = (aluout[1:0] == 2'b00);
                misal        = (aluout[1:0] != 2'b00);
                new_ent.be   = 4'b1111;
                new_ent.data = writedata;
            end
            default: ;
        endcase
    end

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;

    // A pop in the same cycle frees a slot, so a full buffer still accepts.
    assign deq   = mem.mem_valid & mem.mem_ready;
    assign enq   = legal & (~full | deq);
    assign stall = legal & full & ~deq;

    // Drain port: derived from state only, so it drops with the async reset.
    assign mem.mem_valid = ~empty;
    assign mem.mem_addr  = {ent_q[rd_ptr].waddr, 2'b00};
    assign mem.mem_wdata = ent_q[rd_ptr].data;
    assign mem.mem_be    = ent_q[rd_ptr].be;

    // Load forwarding: oldest to newest so the youngest matching store wins
    // each lane. The entry popping this cycle still counts because memory
    // only commits it at the edge; the store being presented now does not.
    always_comb begin
        logic [PW-1:0] idx;
        readdata = mem.mem_rdata;
        idx      = rd_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (vld_q[idx] && (ent_q[idx].waddr == aluout[AW-1:2])) begin
                for (int j = 0; j < 4; j++) begin
                    if (ent_q[idx].be[j]) begin
                        readdata[8*j +: 8] = ent_q[idx].data[8*j +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            misalign <= 1'b0;
            vld_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            misalign <= misal;
            if (deq) begin
                vld_q[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PW'(1);
            end
            // When full with a pop, wr_ptr == rd_ptr; this later write
            // re-validates the slot just freed.
            if (enq) begin
                vld_q[wr_ptr] <= 1'b1;
                ent_q[wr_ptr] <= new_ent;
                wr_ptr        <= wr_ptr + PW'(1);
            end
            case ({enq, deq})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_store_buffer.sv
// Purpose : directed self-checking bench for dmem_store_buffer.
// Latency : inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: mem_ready is driven by the bench; every drain loop is bounded.
module tb_dmem_store_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  memwrite;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        stall;
    logic        misalign;
    logic [2:0]  count;
    logic        empty;

    int checks = 0;
    int errors = 0;

    // {addr, be, wdata} of every accepted memory write
    logic [67:0] wq[$];

    dmem_store_buffer_if #(.AW(32)) mif ();

    dmem_store_buffer #(.DEPTH(4), .AW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .aluout    (aluout),
        .writedata (writedata),
        .readdata  (readdata),
        .stall     (stall),
        .misalign  (misalign),
        .count     (count),
        .empty     (empty),
        .mem       (mif.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset === 1'b1 && mif.mem_valid === 1'b1 && mif.mem_ready === 1'b1)
            wq.push_back({mif.mem_addr, mif.mem_be, mif.mem_wdata});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        memwrite  = sz;
        aluout    = a;
        writedata = d;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        memwrite = 2'b00;
        mif.mem_ready = 1'b1;
        while (empty !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        chk({tag, "_drained"}, {31'd0, empty}, 32'd1);
        mif.mem_ready = 1'b0;
    endtask

    task automatic chk_wr(input string tag, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        logic [67:0] item;
        chk({tag, "_present"}, {31'd0, wq.size() > 0}, 32'd1);
        item = '0;
        if (wq.size() > 0) item = wq.pop_front();
        chk({tag, "_addr"}, item[67:36], a);
        chk({tag, "_be"}, {28'd0, item[35:32]}, {28'd0, be});
        chk({tag, "_data"}, item[31:0], d);
    endtask

    initial begin
        reset = 1'b0;
        memwrite = 2'b00;
        aluout = '0;
        writedata = '0;
        mif.mem_ready = 1'b0;
        mif.mem_rdata = '0;

        // reset state
        @(negedge clk);
        chk("rst_valid", {31'd0, mif.mem_valid}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        chk("rst_count", {29'd0, count}, 32'd0);
        cyc();
        reset = 1'b1;
        cyc();

        // 1: single word store, no same-cycle bypass, popped on first presentation
        wq.delete();
        mif.mem_ready = 1'b1;
        store(2'b11, 32'h100, 32'hDEADBEEF);
        @(negedge clk);
        chk("t1_stall", {31'd0, stall}, 32'd0);
        chk("t1_nobypass", {31'd0, mif.mem_valid}, 32'd0);
        cyc();
        memwrite = 2'b00;
        @(negedge clk);
        chk("t1_valid", {31'd0, mif.mem_valid}, 32'd1);
        chk("t1_addr", mif.mem_addr, 32'h100);
        chk("t1_be", {28'd0, mif.mem_be}, 32'hF);
        chk("t1_wdata", mif.mem_wdata, 32'hDEADBEEF);
        chk("t1_count", {29'd0, count}, 32'd1);
        cyc();
        @(negedge clk);
        chk("t1_empty", {31'd0, empty}, 32'd1);
        chk("t1_valid_off", {31'd0, mif.mem_valid}, 32'd0);
        chk_wr("t1_w0", 32'h100, 4'hF, 32'hDEADBEEF);
        cyc();

        // 2: byte and half stores merged into a load
        mif.mem_ready = 1'b0;
        store(2'b01, 32'h203, 32'h000000AA);
        cyc();
        store(2'b10, 32'h200, 32'h00001234);
        cyc();
        memwrite = 2'b00;
        aluout = 32'h200;
        mif.mem_rdata = 32'h0;
        @(negedge clk);
        chk("t2_fwd", readdata, 32'hAA001234);
        chk("t2_count", {29'd0, count}, 32'd2);
        chk("t2_head_be", {28'd0, mif.mem_be}, 32'h8);
        chk("t2_head_data", mif.mem_wdata, 32'hAAAAAAAA);
        mif.mem_rdata = 32'h55667788;
        @(posedge clk);
        #1;
        chk("t2_fwd_mix", readdata, 32'hAA661234);
        aluout = 32'h204;
        #1;
        chk("t2_other_word", readdata, 32'h55667788);
        mif.mem_rdata = 32'h0;
        drain("t2");
        chk_wr("t2_w0", 32'h200, 4'b1000, 32'hAAAAAAAA);
        chk_wr("t2_w1", 32'h200, 4'b0011, 32'h12341234);

        // 3: fill, stall on the fifth store, accept it on a same-cycle pop
        wq.delete();
        for (int i = 0; i < 4; i++) begin
            store(2'b11, 32'h500 + 32'(4 * i), 32'hA0 + 32'(i));
            @(negedge clk);
            chk($sformatf("t3_nostall%0d", i), {31'd0, stall}, 32'd0);
            cyc();
        end
        store(2'b11, 32'h510, 32'hA4);
        @(negedge clk);
        chk("t3_stall", {31'd0, stall}, 32'd1);
        chk("t3_full", {29'd0, count}, 32'd4);
        cyc();
        mif.mem_ready = 1'b1;
        @(negedge clk);
        chk("t3_accept", {31'd0, stall}, 32'd0);
        cyc();
        memwrite = 2'b00;
        mif.mem_ready = 1'b0;
        @(negedge clk);
        chk("t3_count_held", {29'd0, count}, 32'd4);
        chk("t3_head", mif.mem_addr, 32'h504);
        drain("t3");
        for (int i = 0; i < 5; i++)
            chk_wr($sformatf("t3_w%0d", i), 32'h500 + 32'(4 * i), 4'hF, 32'hA0 + 32'(i));

        // 4: newest store to the same word wins; current store not forwarded
        wq.delete();
        store(2'b11, 32'h300, 32'h11111111);
        cyc();
        store(2'b11, 32'h300, 32'h22222222);
        @(negedge clk);
        chk("t4_no_self_fwd", readdata, 32'h11111111);
        cyc();
        memwrite = 2'b00;
        @(negedge clk);
        chk("t4_newest", readdata, 32'h22222222);
        drain("t4");
        chk_wr("t4_w0", 32'h300, 4'hF, 32'h11111111);
        chk_wr("t4_w1", 32'h300, 4'hF, 32'h22222222);

        // 5: misaligned half and word dropped
        store(2'b10, 32'h401, 32'h0000BEEF);
        @(negedge clk);
        chk("t5_sh_stall", {31'd0, stall}, 32'd0);
        cyc();
        store(2'b11, 32'h402, 32'hCAFEF00D);
        @(negedge clk);
        chk("t5_sh_pulse", {31'd0, misalign}, 32'd1);
        chk("t5_sw_stall", {31'd0, stall}, 32'd0);
        chk("t5_count_a", {29'd0, count}, 32'd0);
        cyc();
        memwrite = 2'b00;
        @(negedge clk);
        chk("t5_sw_pulse", {31'd0, misalign}, 32'd1);
        cyc();
        @(negedge clk);
        chk("t5_pulse_end", {31'd0, misalign}, 32'd0);
        chk("t5_count_b", {29'd0, count}, 32'd0);
        chk("t5_empty", {31'd0, empty}, 32'd1);
        cyc();

        // 6: asynchronous reset discards pending stores
        for (int i = 0; i < 3; i++) begin
            store(2'b11, 32'h600 + 32'(4 * i), 32'h60 + 32'(i));
            cyc();
        end
        memwrite = 2'b00;
        @(negedge clk);
        chk("t6_pending", {29'd0, count}, 32'd3);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_async_valid", {31'd0, mif.mem_valid}, 32'd0);
        chk("t6_async_count", {29'd0, count}, 32'd0);
        chk("t6_async_empty", {31'd0, empty}, 32'd1);
        cyc();
        reset = 1'b1;
        wq.delete();
        mif.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        chk("t6_no_stale", wq.size(), 32'd0);
        chk("t6_valid_after", {31'd0, mif.mem_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
